// File: rtl/sram_responder.sv
// Behavioural asynchronous-SRAM target: registered pin sampling, programmable read latency, byte lanes.
// Optional protocol checker enabled with `define SRAM_RESPONDER_PROTOCOL_CHECK_EN.
module sram_responder #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned DEPTH_W = 10,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_SRAM_ADDR,
  inout  wire  [15:0]       io_SRAM_DQ,
  input  logic              i_SRAM_CE_N,
  input  logic              i_SRAM_OE_N,
  input  logic              i_SRAM_WE_N,
  input  logic              i_SRAM_UB_N,
  input  logic              i_SRAM_LB_N,
  output logic              o_busy,
  output logic [15:0]       o_rd_cnt,
  output logic [15:0]       o_wr_cnt,
  output logic              o_err
);

  localparam int unsigned DEPTH  = 2 ** DEPTH_W;
  localparam logic [3:0]  LAT_M1 = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ARM} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DEPTH_W-1:0]  wr_addr_q;
  logic [15:0]         wr_data_q;
  logic [1:0]          wr_be_q;
  logic [15:0]         rd_cnt_q, wr_cnt_q;
  logic                ub_oe_q, lb_oe_q;
  logic [15:0]         mem_q [DEPTH];
  logic [15:0]         rd_data;
  logic                wr_go, rd_go, addr_chg, commit;

  assign wr_go    = ~i_SRAM_CE_N & ~i_SRAM_WE_N;
  assign rd_go    = ~i_SRAM_CE_N & ~i_SRAM_OE_N;
  assign addr_chg = (i_SRAM_ADDR != rd_addr_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_go) begin
          state_d = WR_ARM;
        end else if (rd_go) begin
          rd_addr_d = i_SRAM_ADDR;
          cnt_d     = LAT_M1;
          state_d   = (RD_LAT == 1) ? RD_DRIVE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wr_go) begin
          state_d = WR_ARM;
        end else if (!rd_go) begin
          state_d = IDLE;
        end else if (addr_chg) begin
          rd_addr_d = i_SRAM_ADDR;
          cnt_d     = LAT_M1;
        end else if (cnt_q <= 4'd1) begin
          // cnt_q of 0 only occurs for RD_LAT=1 after an address change
          state_d = RD_DRIVE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_DRIVE: begin
        if (wr_go) begin
          state_d = WR_ARM;
        end else if (!rd_go) begin
          state_d = IDLE;
        end else if (addr_chg) begin
          rd_addr_d = i_SRAM_ADDR;
          cnt_d     = LAT_M1;
          state_d   = RD_WAIT;
        end
      end
      WR_ARM: begin
        if (!wr_go) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      ub_oe_q   <= 1'b0;
      lb_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      if (wr_go) begin
        wr_addr_q <= i_SRAM_ADDR[DEPTH_W-1:0];
        wr_data_q <= io_SRAM_DQ;
        wr_be_q   <= {~i_SRAM_UB_N, ~i_SRAM_LB_N};
      end
      if (commit) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (state_d == RD_DRIVE && state_q != RD_DRIVE) rd_cnt_q <= rd_cnt_q + 16'd1;
      ub_oe_q <= (state_d == RD_DRIVE) & ~i_SRAM_UB_N;
      lb_oe_q <= (state_d == RD_DRIVE) & ~i_SRAM_LB_N;
    end
  end

  // Array has no reset: contents survive i_rst_n; commit is gated by the reset state
  always_ff @(posedge i_clk) begin
    if (commit) begin
      if (wr_be_q[1]) mem_q[wr_addr_q][15:8] <= wr_data_q[15:8];
      if (wr_be_q[0]) mem_q[wr_addr_q][7:0]  <= wr_data_q[7:0];
    end
  end

  assign rd_data    = mem_q[rd_addr_q[DEPTH_W-1:0]];
  assign io_SRAM_DQ = {ub_oe_q ? rd_data[15:8] : 8'hzz, lb_oe_q ? rd_data[7:0] : 8'hzz};
  assign o_busy     = (state_q != IDLE);
  assign o_rd_cnt   = rd_cnt_q;
  assign o_wr_cnt   = wr_cnt_q;

`ifdef SRAM_RESPONDER_PROTOCOL_CHECK_EN
  logic              err_q;
  logic [ADDR_W-1:0] arm_addr_q;
  logic              viol;

  always_comb begin
    viol = 1'b0;
    if (~i_SRAM_CE_N & ~i_SRAM_OE_N & ~i_SRAM_WE_N) viol = 1'b1;
    if (state_q == WR_ARM && i_SRAM_ADDR != arm_addr_q) viol = 1'b1;
    if (i_SRAM_CE_N !== 1'b1 &&
        $isunknown({i_SRAM_CE_N, i_SRAM_OE_N, i_SRAM_WE_N, i_SRAM_UB_N, i_SRAM_LB_N}))
      viol = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q      <= 1'b0;
      arm_addr_q <= '0;
    end else begin
      if (viol) err_q <= 1'b1;
      if (wr_go) arm_addr_q <= i_SRAM_ADDR;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
